// File: rtl/mem_arbiter_pkg.sv
// Shared configuration for the memory arbiter: datapath width, FSM states,
// grant identifiers and the default abort timeout.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif

package mem_arbiter_pkg;

  // Default number of BUSY cycles a transaction may wait for ready
  localparam int MAX_WAIT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_LS_BUSY = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch, load/store) arbiter onto one memory request port.
// Latency: request in IDLE at N -> o_mem_valid at N+1; ack one cycle after ready.
// Backpressure: requesters stall until their ack; memory stalls via i_mem_ready.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT,
  parameter int CNT_W    = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_if_req,
  input  logic [`CPU_WIDTH-1:0]   i_if_addr,
  output logic                    o_if_ack,
  output logic [`CPU_WIDTH-1:0]   o_if_rdata,
  output logic                    o_if_stall,
  input  logic                    i_ls_req,
  input  logic                    i_ls_wen,
  input  logic [`CPU_WIDTH-1:0]   i_ls_addr,
  input  logic [`CPU_WIDTH-1:0]   i_ls_wdata,
  input  logic [7:0]              i_ls_wmask,
  output logic                    o_ls_ack,
  output logic [`CPU_WIDTH-1:0]   o_ls_rdata,
  output logic                    o_ls_stall,
  output logic                    o_mem_valid,
  output logic                    o_mem_wen,
  output logic [`CPU_WIDTH-1:0]   o_mem_addr,
  output logic [`CPU_WIDTH-1:0]   o_mem_wdata,
  output logic [7:0]              o_mem_wmask,
  input  logic                    i_mem_ready,
  input  logic [`CPU_WIDTH-1:0]   i_mem_rdata,
  output logic                    o_timeout
);

  arb_state_e              state_q, state_d;
  grant_e                  last_q, last_d;
  logic                    mem_valid_q, mem_valid_d;
  logic                    wen_q, wen_d;
  logic [`CPU_WIDTH-1:0]   addr_q, addr_d;
  logic [`CPU_WIDTH-1:0]   wdata_q, wdata_d;
  logic [7:0]              wmask_q, wmask_d;
  logic [`CPU_WIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic [`CPU_WIDTH-1:0]   ls_rdata_q, ls_rdata_d;
  logic                    if_ack_q, if_ack_d;
  logic                    ls_ack_q, ls_ack_d;
  logic                    timeout_q, timeout_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // A requester still holds req during its own ack cycle; that is the
  // completed request, not a new one, so it must not be re-granted.
  logic if_req_eff, ls_req_eff, ls_wins;
  assign if_req_eff = i_if_req & ~if_ack_q;
  assign ls_req_eff = i_ls_req & ~ls_ack_q;
  assign ls_wins    = ls_req_eff & (~if_req_eff | (last_q != GNT_LS));

  // Next-state: arbitration in IDLE, completion/abort and wait counting in BUSY
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mem_valid_d = mem_valid_q;
    wen_d       = wen_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ls_wins) begin
          state_d     = ST_LS_BUSY;
          last_d      = GNT_LS;
          mem_valid_d = 1'b1;
          wen_d       = i_ls_wen;
          addr_d      = i_ls_addr;
          wdata_d     = i_ls_wdata;
          wmask_d     = i_ls_wmask;
          cnt_d       = '0;
        end else if (if_req_eff) begin
          state_d     = ST_IF_BUSY;
          last_d      = GNT_IF;
          mem_valid_d = 1'b1;
          wen_d       = 1'b0;
          addr_d      = i_if_addr;
          wdata_d     = '0;
          wmask_d     = '0;
          cnt_d       = '0;
        end
      end
      ST_IF_BUSY, ST_LS_BUSY: begin
        // Ready has priority; abort fires in the MAX_WAIT-th BUSY cycle
        // without ready, so o_mem_valid is high for exactly MAX_WAIT cycles.
        if (i_mem_ready || (cnt_q == CNT_W'(MAX_WAIT - 1))) begin
          state_d     = ST_IDLE;
          mem_valid_d = 1'b0;
          if (!i_mem_ready) begin
            timeout_d = 1'b1;
          end
          if (state_q == ST_LS_BUSY) begin
            ls_ack_d   = 1'b1;
            ls_rdata_d = i_mem_ready ? i_mem_rdata : '0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = i_mem_ready ? i_mem_rdata : '0;
          end
        end
        if (!i_mem_ready && (cnt_q != CNT_W'(MAX_WAIT))) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  // State and all registered outputs; reset drops an in-flight transaction
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      last_q      <= GNT_IF;
      mem_valid_q <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mem_valid_q <= mem_valid_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      if_ack_q    <= if_ack_d;
      ls_ack_q    <= ls_ack_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_if_ack    = if_ack_q;
  assign o_ls_ack    = ls_ack_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_ls_rdata  = ls_rdata_q;
  assign o_if_stall  = i_if_req & ~if_ack_q;
  assign o_ls_stall  = i_ls_req & ~ls_ack_q;
  assign o_mem_valid = mem_valid_q;
  assign o_mem_wen   = wen_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_wmask = wmask_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MAX_WAIT = 4).
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Memory side is modelled by directly driving i_mem_ready/i_mem_rdata.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif

module tb_mem_arbiter;

  logic                  i_clk = 1'b0;
  logic                  i_rst = 1'b1;
  logic                  i_if_req = 1'b0;
  logic [`CPU_WIDTH-1:0] i_if_addr = '0;
  logic                  o_if_ack;
  logic [`CPU_WIDTH-1:0] o_if_rdata;
  logic                  o_if_stall;
  logic                  i_ls_req = 1'b0;
  logic                  i_ls_wen = 1'b0;
  logic [`CPU_WIDTH-1:0] i_ls_addr = '0;
  logic [`CPU_WIDTH-1:0] i_ls_wdata = '0;
  logic [7:0]            i_ls_wmask = '0;
  logic                  o_ls_ack;
  logic [`CPU_WIDTH-1:0] o_ls_rdata;
  logic                  o_ls_stall;
  logic                  o_mem_valid;
  logic                  o_mem_wen;
  logic [`CPU_WIDTH-1:0] o_mem_addr;
  logic [`CPU_WIDTH-1:0] o_mem_wdata;
  logic [7:0]            o_mem_wmask;
  logic                  i_mem_ready = 1'b0;
  logic [`CPU_WIDTH-1:0] i_mem_rdata = '0;
  logic                  o_timeout;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.MAX_WAIT(4), .CNT_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_ack(o_if_ack), .o_if_rdata(o_if_rdata), .o_if_stall(o_if_stall),
    .i_ls_req(i_ls_req), .i_ls_wen(i_ls_wen), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .i_ls_wmask(i_ls_wmask),
    .o_ls_ack(o_ls_ack), .o_ls_rdata(o_ls_rdata), .o_ls_stall(o_ls_stall),
    .o_mem_valid(o_mem_valid), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
    .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
    .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (o_mem_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", o_mem_valid); end
    checks++; if ({o_if_ack, o_ls_ack, o_timeout} !== 3'b000) begin errors++; $display("FAIL rst_acks got %b exp 000", {o_if_ack, o_ls_ack, o_timeout}); end
    checks++; if (o_mem_addr !== 64'h0) begin errors++; $display("FAIL rst_addr got %0h exp 0", o_mem_addr); end
    step; step;
    i_rst = 1'b0;
    step;
    checks++; if (o_mem_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid got %0h exp 0", o_mem_valid); end
  endtask

  task automatic test_fetch;
    i_if_req  = 1'b1;
    i_if_addr = 64'h8000_0000;
    #1;
    checks++; if (o_if_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_pre got %0h exp 1", o_if_stall); end
    step;
    checks++; if (o_mem_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid got %0h exp 1", o_mem_valid); end
    checks++; if (o_mem_addr !== 64'h8000_0000) begin errors++; $display("FAIL fetch_addr got %0h exp 80000000", o_mem_addr); end
    checks++; if ({o_mem_wen, o_mem_wmask} !== 9'h000) begin errors++; $display("FAIL fetch_wen_mask got %0h exp 0", {o_mem_wen, o_mem_wmask}); end
    step; step;
    checks++; if (o_mem_valid !== 1'b1 || o_if_stall !== 1'b1) begin errors++; $display("FAIL fetch_hold got valid %0h stall %0h exp 1 1", o_mem_valid, o_if_stall); end
    i_mem_ready = 1'b1;
    i_mem_rdata = 64'h13;
    step;
    i_mem_ready = 1'b0;
    i_mem_rdata = 64'h0;
    checks++; if (o_if_ack !== 1'b1) begin errors++; $display("FAIL fetch_ack got %0h exp 1", o_if_ack); end
    checks++; if (o_if_rdata !== 64'h13) begin errors++; $display("FAIL fetch_rdata got %0h exp 13", o_if_rdata); end
    checks++; if (o_if_stall !== 1'b0 || o_mem_valid !== 1'b0) begin errors++; $display("FAIL fetch_ack_cycle got stall %0h valid %0h exp 0 0", o_if_stall, o_mem_valid); end
    i_if_req = 1'b0;
    step;
    checks++; if (o_if_ack !== 1'b0 || o_mem_valid !== 1'b0) begin errors++; $display("FAIL fetch_after got ack %0h valid %0h exp 0 0", o_if_ack, o_mem_valid); end
    checks++; if (o_if_rdata !== 64'h13) begin errors++; $display("FAIL fetch_rdata_hold got %0h exp 13", o_if_rdata); end
  endtask

  task automatic test_priority;
    i_if_req  = 1'b1; i_if_addr = 64'hA000;
    i_ls_req  = 1'b1; i_ls_addr = 64'hB000; i_ls_wen = 1'b0;
    step;
    checks++; if (o_mem_addr !== 64'hB000) begin errors++; $display("FAIL prio_ls_first got %0h exp b000", o_mem_addr); end
    i_mem_ready = 1'b1; i_mem_rdata = 64'h1111;
    step;
    i_mem_ready = 1'b0;
    checks++; if (o_ls_ack !== 1'b1 || o_ls_rdata !== 64'h1111) begin errors++; $display("FAIL prio_ls_ack got %0h/%0h exp 1/1111", o_ls_ack, o_ls_rdata); end
    checks++; if (o_if_stall !== 1'b1 || o_ls_stall !== 1'b0) begin errors++; $display("FAIL prio_stalls got if %0h ls %0h exp 1 0", o_if_stall, o_ls_stall); end
    i_ls_addr = 64'hC000;
    step;
    checks++; if (o_mem_addr !== 64'hA000 || o_mem_valid !== 1'b1) begin errors++; $display("FAIL prio_if_second got %0h exp a000", o_mem_addr); end
    checks++; if (o_ls_stall !== 1'b1) begin errors++; $display("FAIL prio_ls_wait got %0h exp 1", o_ls_stall); end
    i_mem_ready = 1'b1; i_mem_rdata = 64'h2222;
    step;
    i_mem_ready = 1'b0;
    checks++; if (o_if_ack !== 1'b1 || o_if_rdata !== 64'h2222) begin errors++; $display("FAIL prio_if_ack got %0h/%0h exp 1/2222", o_if_ack, o_if_rdata); end
    i_if_req = 1'b0;
    step;
    checks++; if (o_mem_addr !== 64'hC000 || o_mem_valid !== 1'b1) begin errors++; $display("FAIL prio_ls_third got %0h exp c000", o_mem_addr); end
    i_mem_ready = 1'b1; i_mem_rdata = 64'h3333;
    step;
    i_mem_ready = 1'b0;
    checks++; if (o_ls_ack !== 1'b1 || o_ls_rdata !== 64'h3333) begin errors++; $display("FAIL prio_ls_ack2 got %0h/%0h exp 1/3333", o_ls_ack, o_ls_rdata); end
    i_ls_req = 1'b0;
    step;
  endtask

  task automatic test_store;
    i_ls_req = 1'b1; i_ls_wen = 1'b1;
    i_ls_addr = 64'h8000_1000; i_ls_wdata = 64'hDEAD_BEEF; i_ls_wmask = 8'h0F;
    step;
    checks++; if (o_mem_wen !== 1'b1 || o_mem_addr !== 64'h8000_1000) begin errors++; $display("FAIL store_req got wen %0h addr %0h exp 1 80001000", o_mem_wen, o_mem_addr); end
    checks++; if (o_mem_wdata !== 64'hDEAD_BEEF || o_mem_wmask !== 8'h0F) begin errors++; $display("FAIL store_data got %0h/%0h exp deadbeef/0f", o_mem_wdata, o_mem_wmask); end
    i_ls_addr = 64'h0; i_ls_wdata = 64'h5A5A; i_ls_wmask = 8'hFF; i_ls_wen = 1'b0;
    step; step;
    checks++; if (o_mem_addr !== 64'h8000_1000 || o_mem_wdata !== 64'hDEAD_BEEF || o_mem_wmask !== 8'h0F || o_mem_wen !== 1'b1) begin errors++; $display("FAIL store_held got %0h/%0h/%0h exp latched values", o_mem_addr, o_mem_wdata, o_mem_wmask); end
    i_mem_ready = 1'b1;
    step;
    i_mem_ready = 1'b0;
    checks++; if (o_ls_ack !== 1'b1 || o_mem_valid !== 1'b0) begin errors++; $display("FAIL store_ack got ack %0h valid %0h exp 1 0", o_ls_ack, o_mem_valid); end
    i_ls_req = 1'b0;
    step;
  endtask

  task automatic test_timeout;
    i_if_req = 1'b1; i_if_addr = 64'h4000;
    step;
    checks++; if (o_mem_valid !== 1'b1 || o_timeout !== 1'b0) begin errors++; $display("FAIL to_start got valid %0h to %0h exp 1 0", o_mem_valid, o_timeout); end
    step; step; step;
    checks++; if (o_mem_valid !== 1'b1 || o_if_ack !== 1'b0) begin errors++; $display("FAIL to_fourth got valid %0h ack %0h exp 1 0", o_mem_valid, o_if_ack); end
    step;
    checks++; if (o_mem_valid !== 1'b0 || o_if_ack !== 1'b1) begin errors++; $display("FAIL to_abort got valid %0h ack %0h exp 0 1", o_mem_valid, o_if_ack); end
    checks++; if (o_if_rdata !== 64'h0 || o_timeout !== 1'b1) begin errors++; $display("FAIL to_data got rdata %0h to %0h exp 0 1", o_if_rdata, o_timeout); end
    i_if_req = 1'b0;
    step;
    i_ls_req = 1'b1; i_ls_wen = 1'b0; i_ls_addr = 64'h5000;
    step;
    checks++; if (o_mem_valid !== 1'b1 || o_mem_addr !== 64'h5000) begin errors++; $display("FAIL to_next_grant got %0h/%0h exp 1/5000", o_mem_valid, o_mem_addr); end
    i_mem_ready = 1'b1; i_mem_rdata = 64'h55;
    step;
    i_mem_ready = 1'b0;
    checks++; if (o_ls_ack !== 1'b1 || o_ls_rdata !== 64'h55 || o_timeout !== 1'b1) begin errors++; $display("FAIL to_next_ack got %0h/%0h/%0h exp 1/55/1", o_ls_ack, o_ls_rdata, o_timeout); end
    i_ls_req = 1'b0;
    step;
  endtask

  task automatic test_reset_mid;
    i_ls_req = 1'b1; i_ls_addr = 64'h6000;
    step;
    checks++; if (o_mem_valid !== 1'b1) begin errors++; $display("FAIL rm_busy got %0h exp 1", o_mem_valid); end
    i_rst = 1'b1;
    #1;
    checks++; if (o_mem_valid !== 1'b0 || o_mem_addr !== 64'h0) begin errors++; $display("FAIL rm_async got valid %0h addr %0h exp 0 0", o_mem_valid, o_mem_addr); end
    checks++; if (o_timeout !== 1'b0 || o_ls_rdata !== 64'h0 || o_if_rdata !== 64'h0) begin errors++; $display("FAIL rm_clear got to %0h ls %0h if %0h exp 0", o_timeout, o_ls_rdata, o_if_rdata); end
    i_ls_req = 1'b0;
    i_mem_ready = 1'b1; i_mem_rdata = 64'h77;
    step;
    i_rst = 1'b0;
    step; step;
    checks++; if (o_ls_ack !== 1'b0 || o_mem_valid !== 1'b0 || o_ls_rdata !== 64'h0) begin errors++; $display("FAIL rm_no_ack got %0h/%0h/%0h exp 0/0/0", o_ls_ack, o_mem_valid, o_ls_rdata); end
    i_mem_ready = 1'b0;
    step;
  endtask

  task automatic test_drop_req;
    i_if_req = 1'b1; i_if_addr = 64'h7000;
    step;
    i_if_req = 1'b0;
    step;
    checks++; if (o_mem_valid !== 1'b1 || o_mem_addr !== 64'h7000) begin errors++; $display("FAIL drop_still_busy got %0h/%0h exp 1/7000", o_mem_valid, o_mem_addr); end
    i_mem_ready = 1'b1; i_mem_rdata = 64'h99;
    step;
    checks++; if (o_if_ack !== 1'b1 || o_if_rdata !== 64'h99) begin errors++; $display("FAIL drop_ack got %0h/%0h exp 1/99", o_if_ack, o_if_rdata); end
    i_mem_rdata = 64'hEE;
    step; step;
    checks++; if (o_if_ack !== 1'b0 || o_ls_ack !== 1'b0 || o_mem_valid !== 1'b0) begin errors++; $display("FAIL idle_ready got %0h/%0h/%0h exp 0/0/0", o_if_ack, o_ls_ack, o_mem_valid); end
    checks++; if (o_if_rdata !== 64'h99) begin errors++; $display("FAIL idle_rdata got %0h exp 99", o_if_rdata); end
    i_mem_ready = 1'b0;
    step;
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_priority;
    test_store;
    test_timeout;
    test_reset_mid;
    test_drop_req;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255: cycles a granted transaction may wait for i_mem_ready before abort.
REQ-002 SHALL have parameter CNT_W, default 8: width of the wait counter, at least clog2(MAX_WAIT+1).
REQ-003 SHALL have ports:
  - i_clk  in  1  clock; one clock domain.
  - i_rst  in  1  reset, asynchronous, active-high.
  - i_if_req  in  1  fetch request, held until ack.
  - i_if_addr  in  `CPU_WIDTH  fetch address.
  - o_if_ack  out  1  one-cycle fetch completion pulse.
  - o_if_rdata  out  `CPU_WIDTH  fetch data, valid with o_if_ack.
  - o_if_stall  out  1  fetch stall to pipeline.
  - i_ls_req  in  1  load/store request, held until ack.
  - i_ls_wen  in  1  1 = store.
  - i_ls_addr  in  `CPU_WIDTH  load/store address.
  - i_ls_wdata  in  `CPU_WIDTH  store data.
  - i_ls_wmask  in  8  store byte mask.
  - o_ls_ack  out  1  one-cycle load/store completion pulse.
  - o_ls_rdata  out  `CPU_WIDTH  load data, valid with o_ls_ack.
  - o_ls_stall  out  1  load/store stall to pipeline.
  - o_mem_valid  out  1  memory request valid.
  - o_mem_wen  out  1  memory write enable.
  - o_mem_addr  out  `CPU_WIDTH  memory address.
  - o_mem_wdata  out  `CPU_WIDTH  memory write data.
  - o_mem_wmask  out  8  memory write mask.
  - i_mem_ready  in  1  memory completion, with data for reads.
  - i_mem_rdata  in  `CPU_WIDTH  memory read data.
  - o_timeout  out  1  sticky abort flag.

Function
REQ-004 SHALL implement an FSM with states IDLE, IF_BUSY and LS_BUSY.
REQ-005 In IDLE, when a request is present, SHALL latch the winner's addr/wen/wdata/wmask into registers and enter the matching BUSY state. A fetch latches wen=0 and wmask=0.
REQ-006 Arbitration SHALL favour LS when both request, except when the previous grant was LS, in which case IF wins. This prevents fetch starvation.
REQ-007 o_mem_valid SHALL be 1 exactly while in a BUSY state. The o_mem_* outputs SHALL come from the latched registers and stay stable until i_mem_ready.
REQ-008 Latency SHALL be: request seen in IDLE at cycle N, o_mem_valid at N+1.
REQ-009 On i_mem_ready in a BUSY state, SHALL register i_mem_rdata into the owner's rdata, pulse the owner's ack in the next cycle, and return to IDLE.
REQ-010 The minimum transaction SHALL be three cycles: grant, valid+ready, ack. A new grant is allowed in the ack cycle.
REQ-011 i_mem_ready while in IDLE SHALL be ignored.
REQ-012 o_xx_stall SHALL equal i_xx_req AND NOT o_xx_ack, combinationally.
REQ-013 A requester dropping req mid-transaction SHALL NOT abort the transaction; its ack still pulses.
REQ-014 On entry to a BUSY state the wait counter SHALL clear, and it SHALL increment each BUSY cycle without i_mem_ready. It saturates at MAX_WAIT.
REQ-015 When the counter equals MAX_WAIT without ready, SHALL abort the transaction:
  - return to IDLE;
  - pulse the owner's ack with rdata = 0;
  - set o_timeout, which stays 1 until reset.
REQ-016 o_if_rdata and o_ls_rdata SHALL hold their last value between acks.

Reset
REQ-017 i_rst SHALL, asynchronously, force:
  - state IDLE;
  - o_mem_valid, o_if_ack, o_ls_ack, o_timeout = 0;
  - all latched request registers, rdata registers and the counter = 0;
  - last-grant = IF.
REQ-018 Reset asserted mid-transaction SHALL drop o_mem_valid immediately and SHALL NOT produce an ack after release.

Structure
REQ-019 The state enum and MAX_WAIT default SHALL live in the shared config package alongside `CPU_WIDTH.
REQ-020 The block SHALL be a single module with no sub-modules. Arbitration and the counter are inline.

Verification
REQ-021 Fetch only, 0x8000_0000, ready two cycles after valid with rdata 0x13 -> o_if_ack one cycle after ready, o_if_rdata=0x13, o_if_stall high until ack.
REQ-022 IF and LS request in the same IDLE cycle -> LS granted first. After ls_ack, IF granted while LS requests again. Then LS.
REQ-023 Store to 0x8000_1000, wdata 0xDEAD_BEEF, wmask 0x0F -> o_mem_wen=1 with identical addr/data/mask held until ready, then o_ls_ack.
REQ-024 MAX_WAIT=4 with ready never asserted -> abort after 4 BUSY cycles, ack with rdata=0, o_timeout=1 sticky, next request served normally.
REQ-025 i_rst pulsed during LS_BUSY -> o_mem_valid 0 in the same cycle, no ack, all outputs at reset values.
REQ-026 i_if_req dropped mid-transaction -> o_if_ack still pulses; i_mem_ready in IDLE -> no ack.
